mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_access_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 167 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory access unit: request sizes, FSM states and lane constants.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS1,
    ACCESS2,
    WAIT,
    RESP
  } state_e;

  localparam int LANE_BITS = 8;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return MASK_BYTE;
      SIZE_HALF: return MASK_HALF;
      SIZE_WORD: return MASK_WORD;
      default:   return 4'b0000;
    endcase
  endfunction

  // True when the access spills past the end of its 32-bit word.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SIZE_HALF) && (offset == 2'b11)) ||
           ((size == SIZE_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane alignment: write-side lane mask and data shift across a word pair,
// read-side right shift with sign or zero extension.
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [55:0] rdata_pair,
  output logic [7:0]  lane_mask,
  output logic [63:0] wdata_pair,
  output logic [31:0] rdata
);

  logic [4:0]  shift_bits;
  logic [31:0] rdata_low;
  logic        fill;

  assign shift_bits = {offset, 3'b000};

  // Lanes above bit 3 of the mask and bits above 31 of the data belong to the next word.
  always_comb begin
    lane_mask  = {4'b0000, base_mask(size)} << offset;
    wdata_pair = {32'b0, wdata} << shift_bits;
    rdata_low  = rdata_pair[shift_bits +: 32];
    fill       = 1'b0;
    rdata      = rdata_low;
    case (size)
      SIZE_BYTE: begin
        fill  = ~is_unsigned & rdata_low[LANE_BITS-1];
        rdata = {{24{fill}}, rdata_low[7:0]};
      end
      SIZE_HALF: begin
        fill  = ~is_unsigned & rdata_low[2*LANE_BITS-1];
        rdata = {{16{fill}}, rdata_low[15:0]};
      end
      default: rdata = rdata_low;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a byte-enabled synchronous RAM.
// Define MEM_ACCESS_UNIT_MISALIGNED_EN to split word-crossing accesses into two RAM cycles.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 16,
  parameter int DATA_BITWIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [ADDRESS_BITWIDTH+1:0] req_addr,
  input  logic [31:0]                 req_wdata,
  output logic                        rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_error,
  output logic [3:0]                  ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0] ram_address,
  output logic [DATA_BITWIDTH-1:0]    ram_data_in,
  input  logic [DATA_BITWIDTH-1:0]    ram_data_out
);

`ifdef MEM_ACCESS_UNIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e                      state;
  logic [1:0]                  size_q;
  logic [1:0]                  offset_q;
  logic                        unsigned_q;
  logic                        write_q;
  logic                        split_q;
  logic [ADDRESS_BITWIDTH-1:0] word_addr_q;
  logic [3:0]                  hi_mask_q;
  logic [31:0]                 hi_data_q;
  logic [31:0]                 lo_word_q;

  logic [1:0]                  align_size;
  logic [1:0]                  align_offset;
  logic                        align_unsigned;
  logic [7:0]                  lane_mask;
  logic [63:0]                 wdata_pair;
  logic [55:0]                 rdata_pair;
  logic [31:0]                 rdata_ext;

  logic                        accept;
  logic                        req_misaligned;
  logic                        req_bad;
  logic                        req_split;
  logic [ADDRESS_BITWIDTH-1:0] req_word_addr;

  assign req_ready      = (state == IDLE);
  assign accept         = req_valid && req_ready;
  assign req_word_addr  = req_addr[ADDRESS_BITWIDTH+1:2];
  assign req_misaligned = crosses_word(req_size, req_addr[1:0]);
  assign req_split      = SPLIT_EN && req_misaligned;
  assign req_bad        = (req_size == SIZE_RSVD) || (req_misaligned && !SPLIT_EN);

  // One aligner serves both directions: live request fields while idle, saved fields afterwards.
  assign align_size     = (state == IDLE) ? req_size     : size_q;
  assign align_offset   = (state == IDLE) ? req_addr[1:0] : offset_q;
  assign align_unsigned = (state == IDLE) ? req_unsigned : unsigned_q;
  assign rdata_pair     = split_q ? {ram_data_out[23:0], lo_word_q}
                                  : {24'b0, ram_data_out};

  mem_access_align u_align (
    .size        (align_size),
    .offset      (align_offset),
    .is_unsigned (align_unsigned),
    .wdata       (req_wdata),
    .rdata_pair  (rdata_pair),
    .lane_mask   (lane_mask),
    .wdata_pair  (wdata_pair),
    .rdata       (rdata_ext)
  );

  // Write strobes and response valid default low so every strobe is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
      rsp_error        <= 1'b0;
      ram_write_enable <= 4'b0000;
      ram_address      <= '0;
      ram_data_in      <= '0;
      size_q           <= 2'b00;
      offset_q         <= 2'b00;
      unsigned_q       <= 1'b0;
      write_q          <= 1'b0;
      split_q          <= 1'b0;
      word_addr_q      <= '0;
      hi_mask_q        <= 4'b0000;
      hi_data_q        <= '0;
      lo_word_q        <= '0;
    end else begin
      rsp_valid        <= 1'b0;
      ram_write_enable <= 4'b0000;
      case (state)
        IDLE: begin
          if (accept) begin
            size_q      <= req_size;
            offset_q    <= req_addr[1:0];
            unsigned_q  <= req_unsigned;
            write_q     <= req_write;
            split_q     <= req_split;
            word_addr_q <= req_word_addr;
            hi_mask_q   <= lane_mask[7:4];
            hi_data_q   <= wdata_pair[63:32];
            if (req_bad) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              ram_address      <= req_word_addr;
              ram_write_enable <= req_write ? lane_mask[3:0] : 4'b0000;
              ram_data_in      <= wdata_pair[31:0];
              state            <= ACCESS1;
            end
          end
        end
        ACCESS1: begin
          if (split_q) begin
            ram_address      <= word_addr_q + ADDRESS_BITWIDTH'(1);
            ram_write_enable <= write_q ? hi_mask_q : 4'b0000;
            ram_data_in      <= hi_data_q;
            state            <= ACCESS2;
          end else if (write_q) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        ACCESS2: begin
          if (write_q) begin
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            lo_word_q <= ram_data_out;
            state     <= WAIT;
          end
        end
        WAIT: begin
          rsp_valid <= 1'b1;
          rsp_error <= 1'b0;
          rsp_rdata <= rdata_ext;
          state     <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-level reference memory plus a response scoreboard.
// Compile with MEM_ACCESS_UNIT_MISALIGNED_EN defined to check the split-access configuration.
module tb_mem_access_unit;

  localparam int AW = 16;

`ifdef MEM_ACCESS_UNIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [3:0]    ram_write_enable;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_in;
  logic [31:0]   ram_data_out;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] ref_mem [int];
  logic [31:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  mem_access_unit #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  // Byte-enabled RAM with a registered read port.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_write_enable[i]) ram[ram_address][8*i +: 8] <= ram_data_in[8*i +: 8];
    ram_data_out <= ram[ram_address];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cycle_cnt);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("rsp_cycle", cycle_cnt, mon_e.cyc);
        check_output("rsp_rdata", rsp_rdata, mon_e.rdata);
        check_output("rsp_error", {31'b0, rsp_error}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [AW+1:0] addr, input logic [31:0] wd);
    logic          misaligned, bad, split;
    logic [3:0]    exp_we   [1:4];
    logic [31:0]   exp_wd   [1:4];
    logic [AW-1:0] exp_addr [1:2];
    logic [31:0]   exp_rd;
    logic [AW+1:0] b;
    int            n, lat, slot;
    exp_t          e;

    misaligned = (sz == 2'b01 && addr[1:0] == 2'b11) || (sz == 2'b10 && addr[1:0] != 2'b00);
    bad        = (sz == 2'b11) || (misaligned && !SPLIT_EN);
    split      = misaligned && SPLIT_EN;
    n          = 1 << sz;
    exp_addr[1] = addr[AW+1:2];
    exp_addr[2] = addr[AW+1:2] + 16'd1;
    for (int k = 1; k <= 4; k++) begin
      exp_we[k] = 4'b0000;
      exp_wd[k] = 32'h0;
    end
    exp_rd = 32'h0;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        b    = addr + (AW+2)'(i);
        slot = (b[AW+1:2] == exp_addr[1]) ? 1 : 2;
        if (wr) begin
          exp_we[slot][b[1:0]]         = 1'b1;
          exp_wd[slot][8*b[1:0] +: 8]  = wd[8*i +: 8];
          ref_mem[int'(b)]             = wd[8*i +: 8];
        end else begin
          exp_rd[8*i +: 8] = ref_byte(int'(b));
        end
      end
      if (!wr && !uns && sz == 2'b00 && exp_rd[7])  exp_rd[31:8]  = 24'hFFFFFF;
      if (!wr && !uns && sz == 2'b01 && exp_rd[15]) exp_rd[31:16] = 16'hFFFF;
    end
    lat     = bad ? 1 : (wr ? (split ? 3 : 2) : (split ? 4 : 3));
    e.rdata = (bad || wr) ? 32'h0 : exp_rd;
    e.err   = bad;

    for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
    check_output("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    e.cyc        = cycle_cnt + lat;
    exp_q.push_back(e);

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        check_output("busy_ready", {31'b0, req_ready}, 32'd0);
        if (!bad) check_output("ram_addr_1", {16'b0, ram_address}, {16'b0, exp_addr[1]});
      end
      if (k == 2 && split) check_output("ram_addr_2", {16'b0, ram_address}, {16'b0, exp_addr[2]});
      check_output("ram_we", {28'b0, ram_write_enable}, {28'b0, exp_we[k]});
      if (exp_we[k] != 4'b0000)
        check_output("ram_wdata", ram_data_in & lane_bits(exp_we[k]), exp_wd[k]);
    end
    @(negedge clk);
    check_output("rsp_seen", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic reset_mid_read(input logic [AW+1:0] addr);
    check_output("rmr_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'b10;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    check_output("rmr_we_t1", {28'b0, ram_write_enable}, 32'd0);
    @(negedge clk);
    check_output("rmr_we_rst", {28'b0, ram_write_enable}, 32'd0);
    check_output("rmr_rsp_rst", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("rmr_ready_after", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_output("rmr_no_rsp", {31'b0, rsp_valid}, 32'd0);
      check_output("rmr_we_idle", {28'b0, ram_write_enable}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW+1:0] ra;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = 32'h0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;

    repeat (2) @(negedge clk);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_output("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
    check_output("rst_we", {28'b0, ram_write_enable}, 32'd0);
    check_output("rst_addr", {16'b0, ram_address}, 32'd0);
    check_output("rst_data_in", ram_data_in, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    apply_stimulus(1'b1, 2'b10, 1'b0, 18'h00010, 32'hDEADBEEF);
    apply_stimulus(1'b0, 2'b10, 1'b0, 18'h00010, 32'h0);
    apply_stimulus(1'b1, 2'b00, 1'b0, 18'h00013, 32'h00000080);
    apply_stimulus(1'b0, 2'b00, 1'b0, 18'h00013, 32'h0);
    apply_stimulus(1'b0, 2'b00, 1'b1, 18'h00013, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 18'h0000C, 32'hA5A51234);
    apply_stimulus(1'b0, 2'b01, 1'b0, 18'h0000E, 32'h0);
    apply_stimulus(1'b0, 2'b01, 1'b1, 18'h0000E, 32'h0);
    apply_stimulus(1'b1, 2'b10, 1'b0, 18'h00001, 32'h11223344);
    apply_stimulus(1'b0, 2'b10, 1'b0, 18'h00000, 32'h0);
    apply_stimulus(1'b0, 2'b10, 1'b0, 18'h00004, 32'h0);
    apply_stimulus(1'b1, 2'b01, 1'b0, 18'h00007, 32'h0000BEEF);
    apply_stimulus(1'b0, 2'b01, 1'b1, 18'h00007, 32'h0);
    apply_stimulus(1'b0, 2'b11, 1'b0, 18'h00008, 32'h0);
    apply_stimulus(1'b1, 2'b11, 1'b0, 18'h00008, 32'h55555555);
    apply_stimulus(1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hCAFEF00D);
    apply_stimulus(1'b1, 2'b10, 1'b0, 18'h00000, 32'h0BADC0DE);
    apply_stimulus(1'b0, 2'b10, 1'b0, 18'h3FFFE, 32'h0);
    apply_stimulus(1'b0, 2'b01, 1'b0, 18'h3FFFF, 32'h0);

    reset_mid_read(18'h00010);

    for (int t = 0; t < 60; t++) begin
      ra = 18'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ra = 18'h3FFE0 + 18'($urandom_range(0, 31));
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
